// File: rtl/stream_split_pkg.sv
// Shared sizing helpers for the stream splitter and its output FIFOs.
package stream_split_pkg;

    localparam int unsigned BufEntries = 2;

    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/split_flip_flop_fifo.sv
// Register-based FIFO with registered head; no fall-through, any depth >= 2.
module split_flip_flop_fifo
    import stream_split_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] write_data,
    output logic [width-1:0] read_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = ptr_width(depth);
    localparam int unsigned CntW = $clog2(depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(depth);

    logic [width-1:0] mem_q [depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FullCnt);
    // Full is judged before the edge, so a same-cycle pop does not open room for a push.
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign read_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

endmodule

// File: rtl/stream_split_using_fifos_and_double_buffer.sv
// Splits {a_part, b_part} words into two independent streams through a
// two-entry input buffer and one FIFO per output.
module stream_split_using_fifos_and_double_buffer
    import stream_split_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*width-1:0] in_data,
    output logic               a_valid,
    input  logic               a_ready,
    output logic [width-1:0]   a_data,
    output logic               b_valid,
    input  logic               b_ready,
    output logic [width-1:0]   b_data
);

    logic [2*width-1:0] buf_q [BufEntries];
    logic               buf_head_q, buf_tail_q;
    logic [1:0]         buf_count_q;
    logic               accept, move;
    logic               a_full, b_full, a_empty, b_empty;
    logic [2*width-1:0] head_word;

    assign in_ready  = (buf_count_q < 2'(BufEntries));
    assign accept    = in_valid & in_ready;
    // Both FIFOs are pushed together so the two streams never drift by more than depth.
    assign move      = (buf_count_q != 2'd0) & ~a_full & ~b_full;
    assign head_word = buf_q[buf_head_q];
    assign a_valid   = ~a_empty;
    assign b_valid   = ~b_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_head_q  <= 1'b0;
            buf_tail_q  <= 1'b0;
            buf_count_q <= 2'd0;
        end else begin
            if (accept) buf_tail_q <= ~buf_tail_q;
            if (move)   buf_head_q <= ~buf_head_q;
            unique case ({accept, move})
                2'b10:   buf_count_q <= buf_count_q + 2'd1;
                2'b01:   buf_count_q <= buf_count_q - 2'd1;
                default: buf_count_q <= buf_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[buf_tail_q] <= in_data;
        end
    end

    split_flip_flop_fifo #(
        .width(width),
        .depth(depth)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (move),
        .pop       (a_valid & a_ready),
        .write_data(head_word[2*width-1:width]),
        .read_data (a_data),
        .empty     (a_empty),
        .full      (a_full)
    );

    split_flip_flop_fifo #(
        .width(width),
        .depth(depth)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (move),
        .pop       (b_valid & b_ready),
        .write_data(head_word[width-1:0]),
        .read_data (b_data),
        .empty     (b_empty),
        .full      (b_full)
    );

endmodule
